uart_prog_loader: RTL and testbench

- Parametrised program loader between the UART receiver and main memory.
- Accepts a framed image: 16-bit length header, N data words of WORD_BYTES bytes each, then a checksum byte. Writes each word to memory starting at LOAD_BASE.
- `busy` holds the CPU in reset while an image is being received.
- Adds over the previous loader: configurable word width, length-based framing, checksum validation, an inter-byte timeout and error reporting.

---
 rtl/uart_prog_loader_if.sv | 27 ++
 rtl/uart_prog_loader.sv | 190 +++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_prog_loader_if.sv
// Byte-stream input and memory-write output bundle for the UART program loader.
interface uart_prog_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_BYTES = 2
);
    logic                      start;
    logic                      rx_valid;
    logic [7:0]                rx_byte;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic                      mem_wr;
    logic [8*WORD_BYTES-1:0]   mem_data;
    logic                      busy;
    logic                      done;
    logic                      error;
    logic [1:0]                err_code;
    logic [15:0]               word_count;

    modport master (
        output start, rx_valid, rx_byte,
        input  mem_addr, mem_wr, mem_data, busy, done, error, err_code, word_count
    );

    modport slave (
        input  start, rx_valid, rx_byte,
        output mem_addr, mem_wr, mem_data, busy, done, error, err_code, word_count
    );
endinterface

// File: rtl/uart_prog_loader.sv
// Receives a length-framed, checksummed program image byte by byte and writes
// it word by word into memory from LOAD_BASE, holding the CPU off via busy.
module uart_prog_loader #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    WORD_BYTES     = 2,
    parameter logic [ADDR_WIDTH-1:0] LOAD_BASE      = 'h4000,
    parameter int                    MAX_WORDS      = 8192,
    parameter int                    TIMEOUT_CYCLES = 2_700_000
) (
    input  logic             clk,
    input  logic             rst,
    uart_prog_loader_if.slave bus
);
    localparam int WW   = 8 * WORD_BYTES;
    localparam int BUFW = (WORD_BYTES > 1) ? 8 * (WORD_BYTES - 1) : 8;
    localparam int BIW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM} state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            sum_q, sum_d;
    logic [BIW-1:0]        byte_idx_q, byte_idx_d;
    logic [BUFW-1:0]       word_buf_q, word_buf_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [WW-1:0]         mem_data_q, mem_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [15:0]           word_count_q, word_count_d;

    logic [WW-1:0]         assembled;
    logic [15:0]           len_val;
    logic [7:0]            csum_total;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  len_bad, word_last, last_word, timeout_hit;

    // Earlier bytes of the word sit in word_buf; the incoming byte is the LSB.
    generate
        if (WORD_BYTES > 1) begin : g_multi
            assign assembled = {word_buf_q, bus.rx_byte};
        end else begin : g_single
            assign assembled = bus.rx_byte;
        end
    endgenerate

    assign len_val     = {len_q[15:8], bus.rx_byte};
    assign len_bad     = (len_val == 16'd0) || (32'(len_val) > MAX_WORDS);
    assign word_last   = (byte_idx_q == BIW'(WORD_BYTES - 1));
    assign last_word   = ((word_count_q + 16'd1) == len_q);
    assign csum_total  = sum_q + bus.rx_byte;
    assign word_addr   = LOAD_BASE + ADDR_WIDTH'(32'(word_count_q) * WORD_BYTES);
    // Fires on the edge at which TIMEOUT_CYCLES idle cycles have elapsed since the last byte.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && busy_q && !bus.start && !bus.rx_valid
                         && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            sum_q        <= '0;
            byte_idx_q   <= '0;
            word_buf_q   <= '0;
            timer_q      <= '0;
            mem_addr_q   <= LOAD_BASE;
            mem_wr_q     <= 1'b0;
            mem_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= 2'd0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            byte_idx_q   <= byte_idx_d;
            word_buf_q   <= word_buf_d;
            timer_q      <= timer_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_q     <= mem_wr_d;
            mem_data_q   <= mem_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = LEN_HI;
        end else if (timeout_hit) begin
            state_d = IDLE;
        end else if (bus.rx_valid) begin
            case (state_q)
                LEN_HI:  state_d = LEN_LO;
                LEN_LO:  state_d = len_bad ? IDLE : DATA;
                DATA:    if (word_last && last_word) state_d = CSUM;
                CSUM:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        len_d        = len_q;
        sum_d        = sum_q;
        byte_idx_d   = byte_idx_q;
        word_buf_d   = word_buf_q;
        mem_addr_d   = mem_addr_q;
        mem_wr_d     = 1'b0;
        mem_data_d   = mem_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        err_code_d   = err_code_q;
        word_count_d = word_count_q;
        timer_d      = (bus.start || bus.rx_valid) ? '0 : (busy_q ? timer_q + TW'(1) : timer_q);

        // start outranks everything, so a coincident byte or partial word is dropped.
        if (bus.start) begin
            busy_d       = 1'b1;
            error_d      = 1'b0;
            err_code_d   = 2'd0;
            word_count_d = '0;
            sum_d        = '0;
            byte_idx_d   = '0;
        end else if (timeout_hit) begin
            busy_d     = 1'b0;
            error_d    = 1'b1;
            err_code_d = 2'd3;
        end else if (bus.rx_valid) begin
            case (state_q)
                LEN_HI: begin
                    len_d[15:8] = bus.rx_byte;
                    sum_d       = csum_total;
                end
                LEN_LO: begin
                    len_d = len_val;
                    sum_d = csum_total;
                    if (len_bad) begin
                        busy_d     = 1'b0;
                        error_d    = 1'b1;
                        err_code_d = 2'd1;
                    end
                end
                DATA: begin
                    sum_d      = csum_total;
                    word_buf_d = assembled[BUFW-1:0];
                    if (word_last) begin
                        byte_idx_d   = '0;
                        mem_wr_d     = 1'b1;
                        mem_addr_d   = word_addr;
                        mem_data_d   = assembled;
                        word_count_d = word_count_q + 16'd1;
                    end else begin
                        byte_idx_d = byte_idx_q + BIW'(1);
                    end
                end
                CSUM: begin
                    busy_d = 1'b0;
                    if (csum_total == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        error_d    = 1'b1;
                        err_code_d = 2'd2;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_data   = mem_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.err_code   = err_code_q;
    assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: a 2-byte-word instance at 0x4000 and a 4-byte-word
// instance at 0xFFFC, driven with directed and random frames against a frame model.
module tb_uart_prog_loader;
    logic clk;
    logic rst;

    uart_prog_loader_if #(.ADDR_WIDTH(16), .WORD_BYTES(2)) ba();
    uart_prog_loader_if #(.ADDR_WIDTH(16), .WORD_BYTES(4)) bb();

    uart_prog_loader #(
        .ADDR_WIDTH(16), .WORD_BYTES(2), .LOAD_BASE(16'h4000),
        .MAX_WORDS(8192), .TIMEOUT_CYCLES(100)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ba.slave)
    );

    uart_prog_loader #(
        .ADDR_WIDTH(16), .WORD_BYTES(4), .LOAD_BASE(16'hFFFC),
        .MAX_WORDS(8192), .TIMEOUT_CYCLES(100)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bb.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [47:0] wq_a[$];
    logic [47:0] wq_b[$];
    int          done_a = 0;
    int          done_b = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture every write strobe and done pulse as {addr, data}.
    always @(negedge clk) begin
        if (ba.mem_wr === 1'b1) wq_a.push_back({ba.mem_addr, 16'h0000, ba.mem_data});
        if (bb.mem_wr === 1'b1) wq_b.push_back({bb.mem_addr, bb.mem_data});
        if (ba.done === 1'b1) done_a++;
        if (bb.done === 1'b1) done_b++;
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic drv(input int sel, input logic st, input logic rv, input logic [7:0] b);
        @(negedge clk);
        if (sel == 0) begin
            ba.start = st; ba.rx_valid = rv; ba.rx_byte = b;
        end else begin
            bb.start = st; bb.rx_valid = rv; bb.rx_byte = b;
        end
    endtask

    task automatic obs(input int sel, output logic bz, output logic dn, output logic er,
                       output logic [1:0] cd, output logic [15:0] wc, output logic [15:0] ad,
                       output logic [31:0] dt, output logic wr);
        if (sel == 0) begin
            bz = ba.busy; dn = ba.done; er = ba.error; cd = ba.err_code;
            wc = ba.word_count; ad = ba.mem_addr; dt = {16'h0000, ba.mem_data}; wr = ba.mem_wr;
        end else begin
            bz = bb.busy; dn = bb.done; er = bb.error; cd = bb.err_code;
            wc = bb.word_count; ad = bb.mem_addr; dt = bb.mem_data; wr = bb.mem_wr;
        end
    endtask

    task automatic chk_reset(input int sel, input string tag);
        logic bz, dn, er, wr;
        logic [1:0] cd;
        logic [15:0] wc, ad;
        logic [31:0] dt;
        obs(sel, bz, dn, er, cd, wc, ad, dt, wr);
        chk({tag, " busy"},     64'(bz), 64'd0);
        chk({tag, " done"},     64'(dn), 64'd0);
        chk({tag, " error"},    64'(er), 64'd0);
        chk({tag, " err_code"}, 64'(cd), 64'd0);
        chk({tag, " wcount"},   64'(wc), 64'd0);
        chk({tag, " mem_addr"}, 64'(ad), (sel == 0) ? 64'h4000 : 64'hFFFC);
        chk({tag, " mem_data"}, 64'(dt), 64'd0);
        chk({tag, " mem_wr"},   64'(wr), 64'd0);
    endtask

    // Model: a frame is len_hi, len_lo, len words MSB-first, then a byte making the
    // 8-bit sum of everything zero (plus delta). Word i lands at base + i*wb mod 2^16.
    task automatic run_frame(input int sel, input logic [15:0] len, input logic [31:0] words[$],
                             input logic [7:0] delta, input bit do_start, input string tag);
        int          wb;
        logic [15:0] base;
        logic [7:0]  bq[$];
        logic [47:0] exp_w[$];
        logic [47:0] got[$];
        logic [7:0]  sum, cs;
        bit          len_ok, good;
        int          dcount;
        logic bz, dn, er, wr;
        logic [1:0] cd;
        logic [15:0] wc, ad;
        logic [31:0] dt;

        wb     = (sel == 0) ? 2 : 4;
        base   = (sel == 0) ? 16'h4000 : 16'hFFFC;
        len_ok = (len != 16'd0) && (int'(len) <= 8192);
        good   = len_ok && (delta == 8'd0);
        bq.push_back(len[15:8]);
        bq.push_back(len[7:0]);
        if (len_ok) begin
            for (int i = 0; i < int'(len); i++) begin
                for (int k = wb - 1; k >= 0; k--) bq.push_back(8'(words[i] >> (8 * k)));
                exp_w.push_back({16'(int'(base) + i * wb), words[i]});
            end
            sum = 8'd0;
            foreach (bq[i]) sum = sum + bq[i];
            cs = 8'd0 - sum;
            cs = cs + delta;
            bq.push_back(cs);
        end

        if (sel == 0) begin wq_a.delete(); done_a = 0; end
        else begin wq_b.delete(); done_b = 0; end

        if (do_start) drv(sel, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
        foreach (bq[i]) begin
            if (i > 0) repeat ($urandom_range(0, 2)) drv(sel, 1'b0, 1'b0, 8'h00);
            drv(sel, 1'b0, 1'b1, bq[i]);
        end
        drv(sel, 1'b0, 1'b0, 8'h00);
        #1;
        obs(sel, bz, dn, er, cd, wc, ad, dt, wr);
        chk({tag, " busy"},     64'(bz), 64'd0);
        chk({tag, " done"},     64'(dn), 64'(good));
        chk({tag, " error"},    64'(er), 64'(!good));
        chk({tag, " err_code"}, 64'(cd), !len_ok ? 64'd1 : (good ? 64'd0 : 64'd2));
        chk({tag, " wcount"},   64'(wc), len_ok ? 64'(len) : 64'd0);
        drv(sel, 1'b0, 1'b0, 8'h00);
        #1;
        obs(sel, bz, dn, er, cd, wc, ad, dt, wr);
        chk({tag, " done_gone"}, 64'(dn), 64'd0);

        if (sel == 0) begin got = wq_a; dcount = done_a; end
        else begin got = wq_b; dcount = done_b; end
        chk({tag, " nwrites"}, 64'(got.size()), 64'(exp_w.size()));
        chk({tag, " ndone"},   64'(dcount), 64'(good));
        foreach (exp_w[i]) begin
            if (i < got.size()) chk($sformatf("%s write%0d", tag, i), 64'(got[i]), 64'(exp_w[i]));
        end
        $display("frame %s: dut=%0d len=%0d delta=%0d writes=%0d", tag, sel, len, delta, got.size());
    endtask

    initial begin
        logic [31:0] wl[$];
        logic bz, dn, er, wr;
        logic [1:0] cd;
        logic [15:0] wc, ad;
        logic [31:0] dt;
        int          n;
        logic [7:0]  delta;

        ba.start = 1'b0; ba.rx_valid = 1'b0; ba.rx_byte = 8'h00;
        bb.start = 1'b0; bb.rx_valid = 1'b0; bb.rx_byte = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset(0, "reset_a");
        chk_reset(1, "reset_b");

        wl.delete(); wl.push_back(32'h1234); wl.push_back(32'hABCD);
        run_frame(0, 16'd2, wl, 8'd0, 1'b1, "good_a");
        run_frame(0, 16'd2, wl, 8'd1, 1'b1, "badsum_a");
        wl.delete();
        run_frame(0, 16'd0, wl, 8'd0, 1'b1, "len0_a");
        run_frame(0, 16'd8193, wl, 8'd0, 1'b1, "lenmax_a");

        // Silence after a partial word: timeout exactly 100 idle cycles after the last byte.
        wq_a.delete();
        drv(0, 1'b1, 1'b0, 8'h00);
        drv(0, 1'b0, 1'b1, 8'h00);
        drv(0, 1'b0, 1'b1, 8'h01);
        drv(0, 1'b0, 1'b1, 8'h12);
        repeat (100) drv(0, 1'b0, 1'b0, 8'h00);
        #1;
        obs(0, bz, dn, er, cd, wc, ad, dt, wr);
        chk("tmo_early busy",  64'(bz), 64'd1);
        chk("tmo_early error", 64'(er), 64'd0);
        drv(0, 1'b0, 1'b0, 8'h00);
        #1;
        obs(0, bz, dn, er, cd, wc, ad, dt, wr);
        chk("tmo busy",     64'(bz), 64'd0);
        chk("tmo error",    64'(er), 64'd1);
        chk("tmo err_code", 64'(cd), 64'd3);
        chk("tmo nwrites",  64'(wq_a.size()), 64'd0);
        $display("timeout: busy=%0d error=%0d code=%0d", bz, er, cd);

        // Restart in the middle of a word, then a clean frame without another start.
        wq_a.delete();
        drv(0, 1'b1, 1'b0, 8'h00);
        drv(0, 1'b0, 1'b1, 8'h00);
        drv(0, 1'b0, 1'b1, 8'h02);
        drv(0, 1'b0, 1'b1, 8'h12);
        drv(0, 1'b1, 1'b0, 8'h00);
        drv(0, 1'b0, 1'b0, 8'h00);
        #1;
        obs(0, bz, dn, er, cd, wc, ad, dt, wr);
        chk("restart busy",    64'(bz), 64'd1);
        chk("restart error",   64'(er), 64'd0);
        chk("restart nwrites", 64'(wq_a.size()), 64'd0);
        wl.delete(); wl.push_back(32'h5566); wl.push_back(32'h7788); wl.push_back(32'h99AA);
        run_frame(0, 16'd3, wl, 8'd0, 1'b0, "restart_a");

        for (int r = 0; r < 12; r++) begin
            wl.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) wl.push_back(32'($urandom_range(0, 16'hFFFF)));
            delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            run_frame(0, 16'(n), wl, delta, 1'b1, $sformatf("rand_a%0d", r));
        end

        // Asynchronous reset mid-frame, checked before the next clock edge.
        wq_a.delete();
        drv(0, 1'b1, 1'b0, 8'h00);
        drv(0, 1'b0, 1'b1, 8'h00);
        drv(0, 1'b0, 1'b1, 8'h03);
        drv(0, 1'b0, 1'b1, 8'h12);
        drv(0, 1'b0, 1'b1, 8'h34);
        drv(0, 1'b0, 1'b1, 8'h56);
        drv(0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("rstmid pre_writes", 64'(wq_a.size()), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_reset(0, "rstmid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wl.delete(); wl.push_back(32'h0F0F);
        run_frame(0, 16'd1, wl, 8'd0, 1'b1, "after_rst_a");

        wl.delete(); wl.push_back(32'hDEADBEEF); wl.push_back(32'h01234567);
        run_frame(1, 16'd2, wl, 8'd0, 1'b1, "wrap_b");
        for (int r = 0; r < 8; r++) begin
            wl.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wl.push_back($urandom);
            delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            run_frame(1, 16'(n), wl, delta, 1'b1, $sformatf("rand_b%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
